uart_out_responder: RTL

- Responder side of the core's I/O output path: consumes the `out_req`/`out_data` pulse pair from the memory-access stage.
- Buffers requests in a FIFO and serializes them onto a UART TX line, 8N1, LSB first.
- Sits between the memory-access stage and the board's serial pin.
- Exposes FIFO-full and overflow status so the core can stall or flag lost output.

---
 rtl/uart_out_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_out_responder.sv
// Buffers out_req bytes in a FIFO and sends them as 8N1 UART frames on txd, LSB first.
// Optional macro UART_OUT_WORD_MODE_EN: FIFO holds full 32-bit words, each sent as 4 little-endian frames.
module uart_out_responder #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16,
  parameter int LOG_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        out_req,
  input  logic [31:0] out_data,
  output logic        txd,
  output logic        fifo_full,
  output logic        tx_busy,
  output logic        overflow
);

`ifdef UART_OUT_WORD_MODE_EN
  localparam int W = 32;
`else
  localparam int W = 8;
`endif
  localparam int CW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [W-1:0]         mem_q [FIFO_DEPTH];
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 overflow_q;

  state_t               state_q;
  logic [CW-1:0]        baud_q;
  logic [2:0]           bit_q;
  logic [W-1:0]         shift_q;
  logic                 txd_q;
`ifdef UART_OUT_WORD_MODE_EN
  logic [1:0]           byte_q;
`else
  logic                 unused_hi;
  assign unused_hi = ^out_data[31:8];
`endif

  logic push, pop, baud_last;

  assign fifo_full = (count_q == (LOG_DEPTH+1)'(FIFO_DEPTH));
  assign push      = out_req && !fifo_full;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign baud_last = (baud_q == CW'(CLK_PER_BIT - 1));

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (LOG_DEPTH+1)'(1);
      2'b01:   count_d = count_q - (LOG_DEPTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (out_req && fifo_full) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= out_data[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
`ifdef UART_OUT_WORD_MODE_EN
      byte_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          txd_q  <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= START;
            txd_q   <= 1'b0;
`ifdef UART_OUT_WORD_MODE_EN
            byte_q  <= '0;
`endif
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            txd_q   <= shift_q[0];
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q  <= '0;
            // Shifting on every data bit leaves the next byte of a word at the bottom.
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              txd_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
`ifdef UART_OUT_WORD_MODE_EN
            if (byte_q != 2'd3) begin
              byte_q  <= byte_q + 2'd1;
              state_q <= START;
              txd_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
`else
            state_q <= IDLE;
`endif
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign overflow = overflow_q;
  assign tx_busy  = (state_q != IDLE) || (count_q != '0);

endmodule
